mem_app_bridge: RTL

Converts one 32-bit core memory request at a time into a 128-bit DDR3 application-interface transaction, and returns the selected 32-bit word to the requester. Sits between the arbitrated core request mux (upstream) and the external memory controller app port (downstream). Handles lane selection, write masking and the independent command/write-data handshakes. Holds off all requests until calibration completes.

---
 rtl/mem_bridge_pkg.sv | 23 ++
 rtl/mem_line_cache.sv | 46 ++++
 rtl/mem_app_bridge.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared command codes, FSM state encoding and lane geometry for mem_app_bridge.
package mem_bridge_pkg;

   localparam int LANE_WIDTH = 32;
   localparam int NUM_LANES  = 4;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_ISSUE,
      RESP
   } state_t;

   // Byte-disable mask for a single-lane write: every byte outside lane sel is masked.
   function automatic logic [15:0] lane_mask(input logic [1:0] sel);
      return ~(16'h000F << {sel, 2'b00});
   endfunction

endpackage

// File: rtl/mem_line_cache.sv
// mem_line_cache: one-line 128-bit read cache (tag + valid) with write-through lane update.
//   clk, reset      : clock, asynchronous active-low reset (clears valid)
//   lookup_tag/sel  : tag and lane of the request currently offered
//   hit, hit_word   : combinational hit flag and selected cached lane
//   fill_en/tag/line: load a whole line returned by the controller
//   wr_en, wr_word  : accepted write; updates the cached lane when it hits
module mem_line_cache
   import mem_bridge_pkg::*;
#(
   parameter int TAG_W = 25
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [TAG_W-1:0]                  lookup_tag,
   input  logic [1:0]                        lookup_sel,
   output logic                              hit,
   output logic [LANE_WIDTH-1:0]             hit_word,
   input  logic                              fill_en,
   input  logic [TAG_W-1:0]                  fill_tag,
   input  logic [NUM_LANES*LANE_WIDTH-1:0]   fill_line,
   input  logic                              wr_en,
   input  logic [LANE_WIDTH-1:0]             wr_word
);

   logic                                  valid;
   logic [TAG_W-1:0]                      tag;
   logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  line;

   assign hit      = valid && (tag == lookup_tag);
   assign hit_word = line[lookup_sel];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         tag   <= '0;
         line  <= '0;
      end else if (fill_en) begin
         valid <= 1'b1;
         tag   <= fill_tag;
         line  <= fill_line;
      end else if (wr_en && hit) begin
         line[lookup_sel] <= wr_word;
      end
   end

endmodule

// File: rtl/mem_app_bridge.sv
// mem_app_bridge: converts one 32-bit core request at a time into a 128-bit DDR3 app-interface transaction.
//   clk, reset                 : app-interface clock, asynchronous active-low reset
//   init_calib_complete        : controller calibration done; requests held off until set
//   req_*                      : upstream request (valid/ready, write flag, byte address, write word)
//   resp_valid, resp_rdata     : one-cycle completion pulse and read word
//   app_addr/cmd/en/rdy        : controller command channel
//   app_wdf_*                  : controller write-data channel (single-beat burst)
//   app_rd_data, _valid        : controller read return
// Optional feature: define MEM_APP_BRIDGE_LINE_CACHE_EN to add a one-line read cache.
module mem_app_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 28,
   parameter int APP_DATA_WIDTH = 128,
   parameter int APP_MASK_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      init_calib_complete,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      resp_valid,
   output logic [31:0]               resp_rdata,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   input  logic                      app_rdy,
   output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
   output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   input  logic                      app_wdf_rdy,
   input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
   input  logic                      app_rd_data_valid
);

   state_t     state;
   logic [1:0] sel_q;
   logic       accept;
   logic       cache_hit;
   logic [31:0] cache_word;
   logic       unused;

   assign accept      = (state == IDLE) && req_valid && req_ready;
   assign app_wdf_end = app_wdf_wren;
   assign unused      = ^{req_addr[31:ADDR_WIDTH+1], req_addr[1:0], app_addr[2:0]};

`ifdef MEM_APP_BRIDGE_LINE_CACHE_EN
   mem_line_cache #(.TAG_W(ADDR_WIDTH-3)) u_cache (
      .clk        (clk),
      .reset      (reset),
      .lookup_tag (req_addr[ADDR_WIDTH:4]),
      .lookup_sel (req_addr[3:2]),
      .hit        (cache_hit),
      .hit_word   (cache_word),
      .fill_en    ((state == RD_WAIT) && app_rd_data_valid),
      .fill_tag   (app_addr[ADDR_WIDTH-1:3]),
      .fill_line  (app_rd_data),
      .wr_en      (accept && req_write),
      .wr_word    (req_wdata)
   );
`else
   assign cache_hit  = 1'b0;
   assign cache_word = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         sel_q        <= 2'd0;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         app_en       <= 1'b0;
         app_wdf_wren <= 1'b0;
         app_cmd      <= CMD_WRITE;
         app_addr     <= '0;
         app_wdf_data <= '0;
         app_wdf_mask <= '1;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= init_calib_complete;
               if (accept) begin
                  req_ready    <= 1'b0;
                  sel_q        <= req_addr[3:2];
                  app_addr     <= {req_addr[ADDR_WIDTH:4], 3'b000};
                  app_wdf_data <= {NUM_LANES{req_wdata}};
                  app_wdf_mask <= lane_mask(req_addr[3:2]);
                  app_cmd      <= req_write ? CMD_WRITE : CMD_READ;
                  if (req_write) begin
                     app_en       <= 1'b1;
                     app_wdf_wren <= 1'b1;
                     state        <= WR_ISSUE;
                  end else if (cache_hit) begin
                     resp_rdata <= cache_word;
                     state      <= RESP;
                  end else begin
                     app_en <= 1'b1;
                     state  <= RD_CMD;
                  end
               end
            end
            RD_CMD: if (app_rdy) begin
               app_en <= 1'b0;
               state  <= RD_WAIT;
            end
            RD_WAIT: if (app_rd_data_valid) begin
               resp_rdata <= app_rd_data[{sel_q, 5'd0} +: LANE_WIDTH];
               state      <= RESP;
            end
            WR_ISSUE: begin
               // Command and data channels retire independently, in any order.
               if (app_rdy) app_en <= 1'b0;
               if (app_wdf_rdy) app_wdf_wren <= 1'b0;
               if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) state <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
